fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width in bits.
REQ-002 SHALL have parameter HALT_ADDR, default 128, PC value that ends execution; legal range 0..2^PC_W-1.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address stack entries; legal range 2..16.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, leave IDLE or HALT and begin fetching at PC 0.
REQ-007 SHALL have port stall, input, 1, hold PC and all state this cycle.
REQ-008 SHALL have port branch, input, 1, taken branch (ALU condition AND decoder branch, combined upstream).
REQ-009 SHALL have port call, input, 1, subroutine call to target.
REQ-010 SHALL have port ret, input, 1, return to the top-of-stack address.
REQ-011 SHALL have port target, input, PC_W, absolute branch or call address.
REQ-012 SHALL have port pc, output, PC_W, current instruction address.
REQ-013 SHALL have port fetch_valid, output, 1, pc addresses an instruction to execute this cycle.
REQ-014 SHALL have port done, output, 1, execution reached HALT_ADDR.
REQ-015 SHALL have port fault, output, 1, return-stack overflow or underflow occurred.

Function
REQ-016 SHALL implement states IDLE, RUN, HALT and FAULT.
REQ-017 IDLE SHALL go to RUN on start, with pc already 0.
REQ-018 In RUN, the next pc SHALL follow this priority: stall (hold), ret (pop), call (push pc+1, go to target), branch (go to target), otherwise pc+1.
REQ-019 pc+1 SHALL wrap from 2^PC_W-1 to 0 without a fault, for both increment and call push.
REQ-020 RUN SHALL go to HALT in the cycle after pc equals HALT_ADDR; that matched instruction is not executed.
REQ-021 The HALT_ADDR comparison SHALL be combinational on the current pc.
REQ-022 A call with RAS_DEPTH entries already held SHALL go to FAULT, leave pc and the stack unchanged, and SHALL NOT push.
REQ-023 A ret with an empty stack SHALL go to FAULT and leave pc unchanged.
REQ-024 fetch_valid SHALL be 1 only in RUN with stall=0 and pc not equal to HALT_ADDR.
REQ-025 done SHALL be 1 in HALT and whenever pc equals HALT_ADDR while in RUN; fault SHALL be 1 only in FAULT.
REQ-026 start in HALT SHALL clear pc and the stack and enter RUN; start in FAULT SHALL be ignored, and only reset leaves FAULT.
REQ-027 Control inputs outside RUN SHALL be ignored, except start as above.
REQ-028 Simultaneous call and ret SHALL behave as ret.
REQ-029 stall SHALL take precedence over the HALT_ADDR transition and over any fault condition.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, pc=0, stack empty, fetch_valid=0, done=0 and fault=0, including mid-operation.
REQ-031 The first state change after reset deassertion SHALL occur only on a rising clk edge.

Configuration
REQ-032 Macro FETCH_UNIT_RAS_EN SHALL control the return-address stack.
REQ-033 With FETCH_UNIT_RAS_EN defined, the return-address stack, call/ret handling and the FAULT state SHALL be present as specified above.
REQ-034 Without FETCH_UNIT_RAS_EN, call SHALL behave as branch, ret SHALL be ignored, fault SHALL be tied to 0, and FAULT SHALL be unreachable.

Structure
REQ-035 The state enum type fetch_state_t and the default PC_W width SHALL be defined in shared package core_pkg.
REQ-036 The return-address stack SHALL be one sub-module, ras_stack, with ports push, pop, din, dout, full and empty, instantiated only under FETCH_UNIT_RAS_EN.

Verification
REQ-037 Bench SHALL cover: reset, start, 5 cycles with no controls -> pc 0,1,2,3,4,5 with fetch_valid=1.
REQ-038 Bench SHALL cover: at pc=10 assert branch with target=40 -> pc=40 next cycle; with stall held 3 cycles -> pc stays 40 for 3 cycles.
REQ-039 Bench SHALL cover: at pc=3, call with target=20, then ret at pc=22 -> pc=20, then 21, 22, then 4.
REQ-040 Bench SHALL cover: RAS_DEPTH=4, five nested calls -> fault=1 after the 5th with pc held; a separate run with ret on an empty stack -> fault=1.
REQ-041 Bench SHALL cover: branch to 127 -> pc=128 with done=1 and fetch_valid=0, then HALT; start -> pc=0 in RUN.
REQ-042 Bench SHALL cover: reset pulsed mid-RUN at pc=50 between clock edges -> pc=0 and IDLE immediately; same run without FETCH_UNIT_RAS_EN -> call acts as a branch and fault stays 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and width defaults for the fetch front end.
package core_pkg;

    localparam int unsigned PC_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: LIFO of DEPTH entries with full/empty flags and bulk clear.
module ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [CNT_W-1:0] count;
    logic [W-1:0]     mem [DEPTH];

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[IDX_W'(count - CNT_W'(1))];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

    // Entries need no reset: count alone decides which are valid.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem[IDX_W'(count)] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter sequencer with branch, call/return and halt detection.
// Optional return-address stack and FAULT handling enabled by FETCH_UNIT_RAS_EN.
module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned HALT_ADDR = 128,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            branch,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            done,
    output logic            fault
);

    localparam logic [PC_W-1:0] HALT_PC = PC_W'(HALT_ADDR);

    fetch_state_t    state;
    fetch_state_t    stateNext;
    logic [PC_W-1:0] pcNext;
    logic [PC_W-1:0] pcInc;
    logic            atHalt;

    assign pcInc  = pc + PC_W'(1);
    assign atHalt = (pc == HALT_PC);

`ifdef FETCH_UNIT_RAS_EN
    logic            rasPush;
    logic            rasPop;
    logic            rasClear;
    logic            rasFull;
    logic            rasEmpty;
    logic [PC_W-1:0] rasTop;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .clear (rasClear),
        .push  (rasPush),
        .pop   (rasPop),
        .din   (pcInc),
        .dout  (rasTop),
        .full  (rasFull),
        .empty (rasEmpty)
    );

    assign fault = (state == FAULT);
`else
    logic unusedRet;
    assign unusedRet = ret;
    assign fault     = 1'b0;
`endif

    assign fetch_valid = (state == RUN) && !stall && !atHalt;
    assign done        = (state == HALT) || ((state == RUN) && atHalt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
        end
    end

    // Next state and pc; stall freezes everything, including halt and fault entry.
    always_comb begin
        stateNext = state;
        pcNext    = pc;
`ifdef FETCH_UNIT_RAS_EN
        rasPush   = 1'b0;
        rasPop    = 1'b0;
        rasClear  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = RUN;
                    pcNext    = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (atHalt) begin
                        stateNext = HALT;
`ifdef FETCH_UNIT_RAS_EN
                    end else if (ret) begin
                        if (rasEmpty) begin
                            stateNext = FAULT;
                        end else begin
                            rasPop = 1'b1;
                            pcNext = rasTop;
                        end
                    end else if (call) begin
                        if (rasFull) begin
                            stateNext = FAULT;
                        end else begin
                            rasPush = 1'b1;
                            pcNext  = target;
                        end
                    end else if (branch) begin
                        pcNext = target;
`else
                    end else if (call || branch) begin
                        pcNext = target;
`endif
                    end else begin
                        pcNext = pcInc;
                    end
                end
            end
            HALT: begin
                if (start) begin
                    stateNext = RUN;
                    pcNext    = '0;
`ifdef FETCH_UNIT_RAS_EN
                    rasClear  = 1'b1;
`endif
                end
            end
            default: begin
                stateNext = state;
            end
        endcase
    end

endmodule
